// File: rtl/fpu_div_pkg.sv
// Shared definitions for the binary32 mantissa/exponent divider.
// The optional inexact flag is enabled with the FPU_DIV_INEXACT_EN macro.
package fpu_div_pkg;

   typedef enum logic [1:0] {
      IDLE,
      PREP,
      ITER,
      FIN
   } state_e;

   localparam int          FP_BIAS   = 127;
   localparam logic [7:0]  EXP_MAX   = 8'hFF;
   localparam logic [23:0] QNAN_MANT = 24'hC00000;
   localparam logic [23:0] INF_MANT  = 24'h800000;
   localparam int          ITER_CNT  = 25;
   localparam int          DIFF_SAT  = 24;

endpackage

// File: rtl/fpu_div_unpack.sv
// Combinational binary32 operand classification; zero-exponent operands
// (zeros and denormals) are flushed to zero.
module fpu_div_unpack
   import fpu_div_pkg::*;
(
   input  logic [31:0] op_i,
   output logic [7:0]  exp_o,
   output logic [23:0] mant_o,
   output logic        zero_o,
   output logic        inf_o,
   output logic        nan_o
);

   logic fracNz;

   assign exp_o  = op_i[30:23];
   assign fracNz = (op_i[22:0] != 23'd0);
   assign zero_o = (exp_o == 8'd0);
   assign inf_o  = (exp_o == EXP_MAX) && !fracNz;
   assign nan_o  = (exp_o == EXP_MAX) && fracNz;
   assign mant_o = zero_o ? 24'd0 : {1'b1, op_i[22:0]};

endmodule

// File: rtl/fpu_div_mant.sv
// Iterative restoring divider producing sign, biased exponent and a
// pre-normalized 24-bit quotient; FPU_DIV_INEXACT_EN adds the inexact flag.
module fpu_div_mant
   import fpu_div_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [31:0] op_a,
   input  logic [31:0] op_b,
   output logic        busy,
   output logic        done,
   output logic [32:0] res_vec,
   output logic [4:0]  diff,
   output logic        overflow,
   output logic        div_by_zero,
   output logic        invalid
`ifdef FPU_DIV_INEXACT_EN
   ,
   output logic        inexact
`endif
);

   state_e      state_q, state_d;
   logic [31:0] opA_q, opB_q;
   logic [25:0] rem_q;
   logic [24:0] quo_q;
   logic [4:0]  cnt_q;

   logic [32:0] resVec_q, resVecN;
   logic [4:0]  diff_q, diffN;
   logic        ovf_q, ovfN;
   logic        dbz_q, dbzN;
   logic        inv_q, invN;
   logic        done_q;

   logic [7:0]  expA, expB;
   logic [23:0] mantA, mantB;
   logic        zeroA, infA, nanA, zeroB, infB, nanB;

   fpu_div_unpack uUnpackA (
      .op_i   (opA_q),
      .exp_o  (expA),
      .mant_o (mantA),
      .zero_o (zeroA),
      .inf_o  (infA),
      .nan_o  (nanA)
   );

   fpu_div_unpack uUnpackB (
      .op_i   (opB_q),
      .exp_o  (expB),
      .mant_o (mantB),
      .zero_o (zeroB),
      .inf_o  (infB),
      .nan_o  (nanB)
   );

   logic isSpecial, invalidCase, sgn;
   assign sgn         = opA_q[31] ^ opB_q[31];
   assign isSpecial   = zeroA | infA | nanA | zeroB | infB | nanB;
   assign invalidCase = nanA | nanB | (zeroA & zeroB) | (infA & infB);

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = PREP;
         PREP:    state_d = isSpecial ? FIN : ITER;
         ITER:    if (cnt_q == 5'(ITER_CNT - 1)) state_d = FIN;
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // One restoring step: subtract the divisor when it fits, then shift.
   logic        qBit;
   logic [25:0] remSub;
   assign qBit   = (rem_q >= {2'b00, mantB});
   assign remSub = qBit ? (rem_q - {2'b00, mantB}) : rem_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         opA_q <= '0;
         opB_q <= '0;
         rem_q <= '0;
         quo_q <= '0;
         cnt_q <= '0;
      end else begin
         case (state_q)
            IDLE: if (start) begin
               opA_q <= op_a;
               opB_q <= op_b;
            end
            PREP: begin
               rem_q <= {2'b00, mantA};
               quo_q <= '0;
               cnt_q <= '0;
            end
            ITER: begin
               rem_q <= {remSub[24:0], 1'b0};
               quo_q <= {quo_q[23:0], qBit};
               cnt_q <= cnt_q + 5'd1;
            end
            default: ;
         endcase
      end
   end

   logic signed [9:0] eBase, en, negEn;
   logic [23:0]       mantN;
   assign eBase = $signed({2'b00, expA}) - $signed({2'b00, expB}) + 10'(FP_BIAS);
   assign en    = quo_q[24] ? eBase : eBase - 10'sd1;
   assign negEn = -en;
   assign mantN = quo_q[24] ? quo_q[24:1] : quo_q[23:0];

   // Result selection: special operands override the iterative quotient.
   always_comb begin
      resVecN = {sgn, en[7:0], mantN};
      diffN   = 5'd0;
      ovfN    = 1'b0;
      dbzN    = 1'b0;
      invN    = 1'b0;
      if (invalidCase) begin
         resVecN = {1'b0, EXP_MAX, QNAN_MANT};
         invN    = 1'b1;
      end else if (infA) begin
         resVecN = {sgn, EXP_MAX, INF_MANT};
      end else if (zeroB) begin
         resVecN = {sgn, EXP_MAX, INF_MANT};
         dbzN    = 1'b1;
      end else if (zeroA || infB) begin
         resVecN = {sgn, 8'h00, 24'h000000};
         ovfN    = 1'b1;
         diffN   = 5'(DIFF_SAT);
      end else if (en >= 10'sd255) begin
         resVecN = {sgn, EXP_MAX, INF_MANT};
      end else if (en <= 10'sd0) begin
         resVecN = {sgn, 8'h00, mantN};
         ovfN    = 1'b1;
         diffN   = (negEn > 10'(DIFF_SAT)) ? 5'(DIFF_SAT) : negEn[4:0];
      end
   end

`ifdef FPU_DIV_INEXACT_EN
   logic        inx_q, inxN;
   logic [25:0] lostMask;
   assign lostMask = (26'd1 << (diffN + 5'd1)) - 26'd1;
   assign inxN     = !isSpecial &&
                     ((rem_q != 26'd0) || (ovfN && (({2'b00, mantN} & lostMask) != 26'd0)));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)              inx_q <= 1'b0;
      else if (state_q == FIN) inx_q <= inxN;
   end

   assign inexact = inx_q;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         resVec_q <= '0;
         diff_q   <= '0;
         ovf_q    <= 1'b0;
         dbz_q    <= 1'b0;
         inv_q    <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         done_q <= (state_q == FIN);
         if (state_q == FIN) begin
            resVec_q <= resVecN;
            diff_q   <= diffN;
            ovf_q    <= ovfN;
            dbz_q    <= dbzN;
            inv_q    <= invN;
         end
      end
   end

   assign busy        = (state_q != IDLE);
   assign done        = done_q;
   assign res_vec     = resVec_q;
   assign diff        = diff_q;
   assign overflow    = ovf_q;
   assign div_by_zero = dbz_q;
   assign invalid     = inv_q;

endmodule

// File: tb/tb_fpu_div_mant.sv
// Directed self-checking bench for fpu_div_mant; inexact checks are compiled
// in when FPU_DIV_INEXACT_EN is defined.
module tb_fpu_div_mant;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        start = 1'b0;
   logic [31:0] op_a = '0;
   logic [31:0] op_b = '0;
   logic        busy, done, overflow, div_by_zero, invalid;
   logic [32:0] res_vec;
   logic [4:0]  diff;
`ifdef FPU_DIV_INEXACT_EN
   logic        inexact;
`endif

   int nCompared   = 0;
   int nMismatched = 0;

   typedef struct {
      string       name;
      logic [31:0] a;
      logic [31:0] b;
      logic [40:0] expv;
      logic        inx;
      int          lat;
   } vec_t;

   fpu_div_mant dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .op_a        (op_a),
      .op_b        (op_b),
      .busy        (busy),
      .done        (done),
      .res_vec     (res_vec),
      .diff        (diff),
      .overflow    (overflow),
      .div_by_zero (div_by_zero),
      .invalid     (invalid)
`ifdef FPU_DIV_INEXACT_EN
      ,
      .inexact     (inexact)
`endif
   );

   always #5 clk = ~clk;

   // Launches one operation and returns the number of edges until done (999 on timeout).
   task automatic runOp(input logic [31:0] a, input logic [31:0] b, output int lat);
      @(negedge clk);
      op_a  = a;
      op_b  = b;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      lat = 999;
      for (int n = 1; n <= 40; n++) begin
         @(posedge clk);
         #1;
         if (done) begin
            lat = n;
            break;
         end
      end
   endtask

   task automatic test_reset();
      logic [42:0] obs;
      #2 rst_n = 1'b0;
      #1;
      obs = {busy, done, res_vec, diff, overflow, div_by_zero, invalid};
      nCompared++;
      if (obs !== 43'd0) begin
         nMismatched++;
         $display("[TB] FAIL reset_state: got %h expected 0", obs);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_vectors(input vec_t vt[]);
      int          lat;
      logic [40:0] obs;
      foreach (vt[i]) begin
         runOp(vt[i].a, vt[i].b, lat);
         obs = {res_vec, diff, overflow, div_by_zero, invalid};
         nCompared++;
         if (lat != vt[i].lat) begin
            nMismatched++;
            $display("[TB] FAIL %s_latency: got %0d expected %0d", vt[i].name, lat, vt[i].lat);
         end
         nCompared++;
         if (obs !== vt[i].expv) begin
            nMismatched++;
            $display("[TB] FAIL %s_result: got %h expected %h", vt[i].name, obs, vt[i].expv);
         end
`ifdef FPU_DIV_INEXACT_EN
         nCompared++;
         if (inexact !== vt[i].inx) begin
            nMismatched++;
            $display("[TB] FAIL %s_inexact: got %b expected %b", vt[i].name, inexact, vt[i].inx);
         end
`endif
      end
   endtask

   task automatic test_normal();
      vec_t vt[] = '{
         '{"div_6_2",   32'h40C00000, 32'h40000000, {1'b0, 8'h80, 24'hC00000, 5'd0, 1'b0, 1'b0, 1'b0}, 1'b0, 27},
         '{"div_1_3",   32'h3F800000, 32'h40400000, {1'b0, 8'h7D, 24'hAAAAAA, 5'd0, 1'b0, 1'b0, 1'b0}, 1'b1, 27},
         '{"div_m6_2",  32'hC0C00000, 32'h40000000, {1'b1, 8'h80, 24'hC00000, 5'd0, 1'b0, 1'b0, 1'b0}, 1'b0, 27},
         '{"exp_ovf",   32'h7F000000, 32'h00800000, {1'b0, 8'hFF, 24'h800000, 5'd0, 1'b0, 1'b0, 1'b0}, 1'b0, 27}
      };
      test_vectors(vt);
      @(posedge clk);
      #1;
      nCompared++;
      if (done !== 1'b0) begin
         nMismatched++;
         $display("[TB] FAIL done_single_cycle: got %b expected 0", done);
      end
   endtask

   task automatic test_underflow();
      vec_t vt[] = '{
         '{"uf_min_2",  32'h00800000, 32'h40000000, {1'b0, 8'h00, 24'h800000, 5'd0,  1'b1, 1'b0, 1'b0}, 1'b0, 27},
         '{"uf_min_8",  32'h00800000, 32'h41000000, {1'b0, 8'h00, 24'h800000, 5'd2,  1'b1, 1'b0, 1'b0}, 1'b0, 27},
         '{"uf_sat",    32'h00800000, 32'h71800000, {1'b0, 8'h00, 24'h800000, 5'd24, 1'b1, 1'b0, 1'b0}, 1'b1, 27}
      };
      test_vectors(vt);
   endtask

   task automatic test_special();
      vec_t vt[] = '{
         '{"one_div_0",  32'h3F800000, 32'h00000000, {1'b0, 8'hFF, 24'h800000, 5'd0,  1'b0, 1'b1, 1'b0}, 1'b0, 2},
         '{"mone_div_0", 32'hBF800000, 32'h00000000, {1'b1, 8'hFF, 24'h800000, 5'd0,  1'b0, 1'b1, 1'b0}, 1'b0, 2},
         '{"zero_div_0", 32'h00000000, 32'h00000000, {1'b0, 8'hFF, 24'hC00000, 5'd0,  1'b0, 1'b0, 1'b1}, 1'b0, 2},
         '{"nan_div_1",  32'h7FC00000, 32'h3F800000, {1'b0, 8'hFF, 24'hC00000, 5'd0,  1'b0, 1'b0, 1'b1}, 1'b0, 2},
         '{"inf_div_2",  32'h7F800000, 32'h40000000, {1'b0, 8'hFF, 24'h800000, 5'd0,  1'b0, 1'b0, 1'b0}, 1'b0, 2},
         '{"zero_div_2", 32'h00000000, 32'h40000000, {1'b0, 8'h00, 24'h000000, 5'd24, 1'b1, 1'b0, 1'b0}, 1'b0, 2},
         '{"two_div_inf",32'h40000000, 32'hFF800000, {1'b1, 8'h00, 24'h000000, 5'd24, 1'b1, 1'b0, 1'b0}, 1'b0, 2}
      };
      test_vectors(vt);
   endtask

   task automatic test_back_to_back();
      vec_t vt[] = '{
         '{"b2b_first",  32'h40C00000, 32'h40000000, {1'b0, 8'h80, 24'hC00000, 5'd0, 1'b0, 1'b0, 1'b0}, 1'b0, 27},
         '{"b2b_second", 32'h3F800000, 32'h00000000, {1'b0, 8'hFF, 24'h800000, 5'd0, 1'b0, 1'b1, 1'b0}, 1'b0, 2},
         '{"b2b_third",  32'h3F800000, 32'h40400000, {1'b0, 8'h7D, 24'hAAAAAA, 5'd0, 1'b0, 1'b0, 1'b0}, 1'b1, 27}
      };
      test_vectors(vt);
   endtask

   task automatic test_busy_ignore();
      int          lat = 999;
      int          extraDone = 0;
      logic [40:0] obs;
      @(negedge clk);
      op_a  = 32'h40C00000;
      op_b  = 32'h40000000;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      for (int n = 1; n <= 40; n++) begin
         @(posedge clk);
         #1;
         if (done) begin
            lat = n;
            break;
         end
         if (n == 5) begin
            @(negedge clk);
            op_a  = 32'h3F800000;
            op_b  = 32'h40400000;
            start = 1'b1;
         end
         if (n == 6) begin
            @(negedge clk);
            start = 1'b0;
         end
      end
      obs = {res_vec, diff, overflow, div_by_zero, invalid};
      nCompared++;
      if (lat != 27) begin
         nMismatched++;
         $display("[TB] FAIL busy_ignore_latency: got %0d expected 27", lat);
      end
      nCompared++;
      if (obs !== {1'b0, 8'h80, 24'hC00000, 5'd0, 1'b0, 1'b0, 1'b0}) begin
         nMismatched++;
         $display("[TB] FAIL busy_ignore_result: got %h expected %h", obs,
                  {1'b0, 8'h80, 24'hC00000, 5'd0, 1'b0, 1'b0, 1'b0});
      end
      for (int n = 0; n < 35; n++) begin
         @(posedge clk);
         #1;
         if (done) extraDone++;
      end
      nCompared++;
      if (extraDone != 0) begin
         nMismatched++;
         $display("[TB] FAIL busy_ignore_no_relaunch: got %0d done pulses expected 0", extraDone);
      end
   endtask

   task automatic test_reset_midop();
      int          lat;
      int          strayDone = 0;
      logic [42:0] obs;
      logic [40:0] obs2;
      @(negedge clk);
      op_a  = 32'h3F800000;
      op_b  = 32'h40400000;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (10) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      obs = {busy, done, res_vec, diff, overflow, div_by_zero, invalid};
      nCompared++;
      if (obs !== 43'd0) begin
         nMismatched++;
         $display("[TB] FAIL reset_midop_outputs: got %h expected 0", obs);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int n = 0; n < 40; n++) begin
         @(posedge clk);
         #1;
         if (done) strayDone++;
      end
      nCompared++;
      if (strayDone != 0) begin
         nMismatched++;
         $display("[TB] FAIL reset_midop_no_done: got %0d done pulses expected 0", strayDone);
      end
      runOp(32'h40C00000, 32'h40000000, lat);
      obs2 = {res_vec, diff, overflow, div_by_zero, invalid};
      nCompared++;
      if (lat != 27 || obs2 !== {1'b0, 8'h80, 24'hC00000, 5'd0, 1'b0, 1'b0, 1'b0}) begin
         nMismatched++;
         $display("[TB] FAIL reset_recovery: got lat %0d result %h expected lat 27 result %h", lat, obs2,
                  {1'b0, 8'h80, 24'hC00000, 5'd0, 1'b0, 1'b0, 1'b0});
      end
   endtask

   initial begin
      test_reset();
      test_normal();
      test_underflow();
      test_special();
      test_back_to_back();
      test_busy_ignore();
      test_reset_midop();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule

// File: doc/fpu_div_mant.md
# fpu_div_mant

Iterative mantissa/exponent divider for the FPU divide path. It accepts two IEEE-754 single-precision operands, handles special operands, and computes sign, biased exponent and a 24-bit pre-normalized truncated quotient over 25 restoring-division iterations. Its result is presented as the 33-bit `{sign, exp[7:0], mant[23:0]}` vector plus `diff`/`overflow` underflow controls. That output feeds the divider's normalize/pack stage directly.

## Interface
- No parameters; all widths are fixed for binary32.
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; sampled only when `busy`=0.
- `op_a`  in  32  dividend, binary32.
- `op_b`  in  32  divisor, binary32.
- `busy`  out  1  high whenever the FSM is not IDLE.
- `done`  out  1  one-cycle pulse; result outputs are valid from this cycle.
- `res_vec`  out  33  `{sign, exp[7:0], mant[23:0]}` for the normalizer.
- `diff`  out  5  underflow right-shift minus one.
- `overflow`  out  1  underflow path select for the normalizer (exp forced to 0).
- `div_by_zero`  out  1  finite nonzero / zero.
- `invalid`  out  1  0/0, inf/inf, or any NaN operand.
- `inexact`  out  1  present only with `FPU_DIV_INEXACT_EN`.

## Operation
- FSM states: IDLE, PREP, ITER, FIN.
  - IDLE→PREP on `start`; operands are captured.
  - PREP→FIN for special cases, otherwise PREP→ITER.
  - ITER→FIN after 25 iterations (5-bit counter).
  - FIN→IDLE; result registers load and `done` sets.
- Unpack: hidden bit = 1 when exp≠0. Exp=0 operands (zero/denormal) are flushed to zero.
- Sign = `a[31]^b[31]`.
- e = ea − eb + 127, held as 10-bit signed.
- Restoring division, one quotient bit per cycle:
  - R (26 bits) = ma; for i = 24..0: if R ≥ mb then q[i]=1 and R −= mb; then R <<= 1.
- Pre-normalize:
  - q[24]=1 → mant=q[24:1], en=e.
  - q[24]=0 → mant=q[23:0], en=e−1.
  - Result: mant[23]=1 always.
- Normal result (1 ≤ en ≤ 254): `res_vec={s,en[7:0],mant}`, `overflow`=0, `diff`=0.
- Underflow (en ≤ 0): `overflow`=1, `diff`=min(−en,24), `res_vec={s,8'h00,mant}`.
- Exponent overflow (en ≥ 255): infinity, `{s,8'hFF,24'h800000}`.
- Special cases (no iteration):
  - NaN, 0/0 or inf/inf → `{0,8'hFF,24'hC00000}`, `invalid`=1.
  - x/0 (x nonzero) → infinity with sign s, `div_by_zero`=1.
  - inf/finite → infinity with sign s.
  - 0/x or finite/inf → zero: `{s,8'h00,24'h0}`, `overflow`=1, `diff`=24.
- Flags load together with `res_vec` and hold until the next load.
- `start` while `busy`=1 is ignored; operands are not re-captured.

## Timing
- Normal latency: `done` is high in the cycle after the 27th rising edge following the edge that samples `start`.
- Special-case latency: `done` is high in the cycle after the 2nd rising edge.
- `done` is high for exactly one cycle; `busy` is already 0 in that cycle.
- A new `start` may be sampled in the `done` cycle (back-to-back operation).
- Reset, asynchronous and valid mid-operation:
  - State → IDLE; `busy`, `done` and all flags → 0.
  - `res_vec`, `diff`, `overflow` → 0.
  - Any in-flight operation is discarded; no `done` is produced for it.

## Configuration
- `FPU_DIV_INEXACT_EN` defined:
  - `inexact` port and logic are compiled in.
  - `inexact` = final remainder ≠ 0, OR (underflow AND any mant bit below the shift of diff+1 is nonzero).
  - Forced to 0 for special cases; reset value 0.
- `FPU_DIV_INEXACT_EN` undefined: the port and its logic are absent. All other behaviour is identical.

## Structure
- Package `fpu_div_pkg` holds:
  - FSM state enum.
  - `FP_BIAS`=127, `EXP_MAX`=8'hFF.
  - `QNAN_MANT`=24'hC00000, `INF_MANT`=24'h800000.
  - `ITER_CNT`=25, `DIFF_SAT`=24.
- One sub-module: `fpu_div_unpack`, combinational operand classification (zero/inf/nan flags, hidden-bit mantissa, exponent). It is instantiated once per operand.

## Test plan
- 6.0/2.0 (`op_a`=40C00000, `op_b`=40000000) → after 27 edges `res_vec`={0,8'h80,24'hC00000}, `overflow`=0, `inexact`=0.
- 1.0/3.0 (3F800000/40400000) → `res_vec`={0,8'h7D,24'hAAAAAA}, `inexact`=1.
- Underflow, 2^-126/2.0 (00800000/40000000) → `overflow`=1, `diff`=0, mant=24'h800000.
- 1.0/0 → `done` 2 edges after `start`, `res_vec`={0,8'hFF,24'h800000}, `div_by_zero`=1.
- 0/0 → `res_vec`={0,8'hFF,24'hC00000}, `invalid`=1.
- Busy/reset handling:
  - `start` pulsed at cycle 5 of a busy operation → ignored; the original result is unchanged.
  - `rst_n` low at cycle 10 → all outputs 0 and no `done` for the discarded operation.
